data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Pipelined data-memory responder: the target end of the CPU data-memory request/response interface. Accepts one load or store per cycle from the CPU's memory stage over a valid/ready request channel, holds a word-addressed synchronous array with byte-enable writes, and returns load data over a valid/ready response channel with a fixed one-cycle minimum latency and a 3-entry response queue for back-pressure.

## Interface
- `ADDR_W`, 10: word-address width.
- `DATA_W`, 32: data width; multiple of 8.
- `DEPTH`, 1024: number of words, ≤ 2^ADDR_W.

- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept the request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: store data.
- `req_be` in DATA_W/8: store byte enables; ignored for loads.
- `rsp_valid` out 1: load response present.
- `rsp_ready` in 1: CPU accepts the response.
- `rsp_rdata` out DATA_W: load data.
- `rsp_err` out 1: load address out of range (see Configuration).

## Operation
- Request accepted on a rising edge with `req_valid && req_ready`. Response popped on a rising edge with `rsp_valid && rsp_ready`.
- Store: on the accept edge, write the bytes of `req_wdata` where `req_be[i]`=1 into `mem[req_addr]`. All-zero `req_be` leaves memory unchanged. Stores produce no response.
- Load: on the accept edge, register `mem[req_addr]` into a single in-flight stage. On the next edge, push the in-flight entry into the response queue: 3 entries, FIFO order, each entry holding data and err.
- Credit count = queued entries + in-flight (0..3). `req_ready = (credit < 3)`. It is a function of registered state only, with no combinational path from `rsp_ready` or `req_valid`. A full credit count stalls stores as well as loads.
- `rsp_valid` = queue non-empty. `rsp_rdata`/`rsp_err` show the queue head and stay stable while `rsp_valid && !rsp_ready`.
- Same edge push and pop: occupancy unchanged, order preserved.
- Ordering: a load accepted after a store to the same address returns the new data. Loads complete in acceptance order.
- Memory contents are not reset and are undefined until written.

## Timing
- After reset: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, queue empty, no in-flight load.
- Load latency: accepted at edge N → `rsp_valid`=1 after edge N+1, earliest pop at edge N+2.
- Throughput: with `rsp_ready` held 1, one load per cycle is sustained indefinitely with credit ≤ 2.
- Back-pressure: with `rsp_ready`=0, exactly 3 loads are accepted and `req_ready` drops after the third accept edge. One pop re-raises `req_ready` in the following cycle.
- Reset asserted mid-operation: in-flight and queued loads are discarded with no response. Outputs return to their reset values immediately. Memory contents are retained.

## Configuration
- `DMEM_RANGE_CHECK_EN` defined: an address ≥ `DEPTH` is out of range.
  - Out-of-range store: dropped; memory unchanged.
  - Out-of-range load: returns `rsp_rdata`=0 with `rsp_err`=1, at the same latency and in the same order as any other load.
- Not defined: `rsp_err` is tied 0. Addresses are used modulo `DEPTH` via the low index bits, so `DEPTH` must be a power of two.

## Test plan
- Reset, then store `32'hDEADBEEF` to addr 5 with be=4'hF, then load addr 5. Required: `rsp_valid` two edges after the store accept, `rsp_rdata`=`32'hDEADBEEF`, `rsp_err`=0.
- Store `32'h11223344` with be=4'hF, then store `32'hAABBCCDD` with be=4'b0101 to addr 7, then load addr 7. Required: `32'h11BB33DD`.
- Back-to-back loads of addrs 0..7 (each preloaded with its index) with `rsp_ready`=1. Required: `req_ready` stays 1 throughout, and responses 0..7 arrive in order on consecutive cycles.
- Loads of addrs 1,2,3,4 with `rsp_ready`=0. Required: `req_ready`=0 after the third accept, 4th load held. Then raise `rsp_ready` for 1 cycle: pops 1, and the 4th load is accepted next cycle. Final order 1,2,3,4.
- Two loads outstanding, then assert `reset` low for 1 cycle. Required: `rsp_valid`=0 immediately, no response ever for those loads, `req_ready`=1 after release. A prior store is still readable.
- With `DMEM_RANGE_CHECK_EN`, `DEPTH`=1000: store to addr 1000 then load addr 1000. Required: `rsp_rdata`=0, `rsp_err`=1, and `mem[1000 mod 1024]` aliasing does not occur.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory target: valid/ready load/store requests, byte-enable writes, 3-deep response queue.
// Optional DMEM_RANGE_CHECK_EN: addresses >= DEPTH are dropped (stores) or answered with rsp_err (loads).
module data_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QD    = 3;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd;
    logic              r_if_vld;
    logic              r_if_err;
    logic [QD-1:0][DATA_W-1:0] r_q_data;
    logic [QD-1:0]     r_q_err;
    logic [1:0]        r_head;
    logic [1:0]        r_tail;
    logic [1:0]        r_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic              w_oor;
    logic              w_accept;
    logic              w_st;
    logic              w_ld;
    logic              w_pop;
    logic [1:0]        w_credit;
    logic [DATA_W-1:0] w_push_data;

    assign w_idx = req_addr[IDX_W-1:0];

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    assign w_oor = ({1'b0, req_addr} >= DEPTH_L);
`else
    assign w_oor = 1'b0;
`endif

    // Credit covers the in-flight load so a queue slot is always free when it lands.
    assign w_credit  = r_cnt + {1'b0, r_if_vld};
    assign req_ready = (w_credit != 2'd3);
    assign w_accept  = req_valid && req_ready;
    assign w_st      = w_accept && req_we && !w_oor;
    assign w_ld      = w_accept && !req_we;
    assign rsp_valid = (r_cnt != 2'd0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_rdata = r_q_data[r_head];
    assign rsp_err   = r_q_err[r_head];
    assign w_push_data = r_if_err ? '0 : r_rd;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Array and read register carry no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_st) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) r_mem[w_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
        end
        if (w_ld) r_rd <= r_mem[w_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_vld <= 1'b0;
            r_if_err <= 1'b0;
            r_q_data <= '0;
            r_q_err  <= '0;
            r_head   <= 2'd0;
            r_tail   <= 2'd0;
            r_cnt    <= 2'd0;
        end else begin
            r_if_vld <= w_ld;
            if (w_ld) r_if_err <= w_oor;
            if (r_if_vld) begin
                r_q_data[r_tail] <= w_push_data;
                r_q_err[r_tail]  <= r_if_err;
                r_tail           <= nxt(r_tail);
            end
            if (w_pop) r_head <= nxt(r_head);
            case ({r_if_vld, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus back-to-back, back-pressure and reset sequences.
module tb_data_mem_responder;
    localparam int AW = 10;
    localparam int DW = 32;
`ifdef DMEM_RANGE_CHECK_EN
    localparam int DEP = 1000;
`else
    localparam int DEP = 1024;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int total = 0;
    int bad = 0;

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
        logic [DW-1:0] exp;
        logic          err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [3:0] be, input logic [DW-1:0] e, input logic er);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.be = be; v.exp = e; v.err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request at a negedge; loads are checked for exact 1-cycle latency then data.
    task automatic apply(input int id, input vec_t v);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready) chk($sformatf("req_ready_timeout[%0d]", id), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        if (!v.we) begin
            chk($sformatf("ld_early_valid[%0d]", id), 32'(rsp_valid), 32'd0);
            step();
            chk($sformatf("ld_valid[%0d]", id), 32'(rsp_valid), 32'd1);
            chk($sformatf("ld_data[%0d]", id), rsp_rdata, v.exp);
            chk($sformatf("ld_err[%0d]", id), 32'(rsp_err), 32'(v.err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got[$];
        int seen;

        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        vq.push_back(mk(1, 10'd5,  32'hDEADBEEF, 4'hF, 0, 0));
        vq.push_back(mk(0, 10'd5,  0, 0, 32'hDEADBEEF, 0));
        vq.push_back(mk(1, 10'd7,  32'h11223344, 4'hF, 0, 0));
        vq.push_back(mk(1, 10'd7,  32'hAABBCCDD, 4'b0101, 0, 0));
        vq.push_back(mk(0, 10'd7,  0, 0, 32'h11BB33DD, 0));
        vq.push_back(mk(1, 10'd9,  32'h12345678, 4'hF, 0, 0));
        vq.push_back(mk(1, 10'd9,  32'hCAFEF00D, 4'h0, 0, 0));
        vq.push_back(mk(0, 10'd9,  0, 0, 32'h12345678, 0));
        vq.push_back(mk(1, 10'd10, 32'h00000000, 4'hF, 0, 0));
        vq.push_back(mk(1, 10'd10, 32'hFFFFFFFF, 4'b1000, 0, 0));
        vq.push_back(mk(0, 10'd10, 0, 0, 32'hFF000000, 0));
        vq.push_back(mk(1, 10'd20, 32'h5A5A1234, 4'hF, 0, 0));
`ifdef DMEM_RANGE_CHECK_EN
        vq.push_back(mk(1, 10'd999,  32'h00000099, 4'hF, 0, 0));
        vq.push_back(mk(1, 10'd1000, 32'hBAD0BAD0, 4'hF, 0, 0));
        vq.push_back(mk(0, 10'd1000, 0, 0, 32'h0, 1));
        vq.push_back(mk(0, 10'd999,  0, 0, 32'h00000099, 0));
        vq.push_back(mk(1, 10'd1023, 32'hA5A5A5A5, 4'hF, 0, 0));
        vq.push_back(mk(0, 10'd1023, 0, 0, 32'h0, 1));
        vq.push_back(mk(0, 10'd5,  0, 0, 32'hDEADBEEF, 0));
`else
        vq.push_back(mk(1, 10'd1023, 32'hA5A5A5A5, 4'hF, 0, 0));
        vq.push_back(mk(0, 10'd1023, 0, 0, 32'hA5A5A5A5, 0));
        vq.push_back(mk(0, 10'd5,  0, 0, 32'hDEADBEEF, 0));
`endif
        foreach (vq[i]) apply(i, vq[i]);

        // Back-to-back loads with rsp_ready held high.
        for (int k = 0; k < 8; k++) apply(100 + k, mk(1, AW'(k), 32'(k), 4'hF, 0, 0));
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(c);
                chk($sformatf("b2b_ready[%0d]", c), 32'(req_ready), 32'd1);
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (c >= 1) begin
                chk($sformatf("b2b_valid[%0d]", c - 1), 32'(rsp_valid), 32'd1);
                chk($sformatf("b2b_data[%0d]", c - 1), rsp_rdata, 32'(c - 1));
            end
        end
        step();
        chk("b2b_drain", 32'(rsp_valid), 32'd0);

        // Back-pressure: three loads fill the credits, fourth held until a pop.
        rsp_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(k);
            step();
        end
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_head", rsp_rdata, 32'd1);
        req_addr = AW'(4);
        step();
        step();
        chk("bp_still_low", 32'(req_ready), 32'd0);
        chk("bp_head_stable", rsp_rdata, 32'd1);
        chk("bp_valid_held", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_ready_back", 32'(req_ready), 32'd1);
        chk("bp_head2", rsp_rdata, 32'd2);
        step();
        req_valid = 1'b0;
        chk("bp_refull", 32'(req_ready), 32'd0);
        step();
        rsp_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (rsp_valid) got.push_back(rsp_rdata);
            step();
        end
        chk("bp_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp_order[%0d]", i), (i < got.size()) ? got[i] : 32'hFFFFFFFF, 32'(i + 2));

        // Reset with loads outstanding: they vanish, memory survives.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(1);
        step();
        req_addr = AW'(2);
        step();
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rr_valid", 32'(rsp_valid), 32'd0);
        chk("rr_rdata", rsp_rdata, 32'd0);
        chk("rr_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            step();
            if (rsp_valid) seen++;
        end
        chk("rr_no_rsp", 32'(seen), 32'd0);
        chk("rr_ready", 32'(req_ready), 32'd1);
        apply(200, mk(0, 10'd20, 0, 0, 32'h5A5A1234, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
